sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//  Serial-in parallel-out deserializer: receive end of the team's PISO shift-register link.
//  Collects WIDTH bits LSB-first, one per serial_valid strobe, into a shift register.
//  Each completed word is moved to a separate output holding register and offered on a valid/ready port.
//  Double-buffered: the next frame can be collected while the previous word waits for its consumer.
// PARAMETERS
//  WIDTH   4   data bits per frame (>=2)
//  CNT_W   $clog2(WIDTH+1)   bit-counter width (derived, not overridden)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  serial_in      in   1       serial data bit, sampled when serial_valid=1
//  serial_valid   in   1       bit strobe; one bit accepted per cycle it is high
//  clear          in   1       abort partial frame (sync); held output is untouched
//  parallel_out   out  WIDTH   received word, LSB = first bit received
//  out_valid      out  1       parallel_out holds an unconsumed word
//  out_ready      in   1       consumer accepts word when out_valid & out_ready
//  busy           out  1       partial frame in progress (bit_cnt != 0)
//  bit_cnt        out  CNT_W   bits of current frame received so far
//  overrun        out  1       1-cycle pulse: completed word dropped, holding register full
//  parity_err     out  1       sticky-with-word parity flag (PARITY_CHECK_EN only, else 0)
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-high.
//  - Reset: sr, bit_cnt, parallel_out=0; out_valid, busy, overrun, parity_err=0.
//  - Shift: on serial_valid, sr <= {serial_in, sr[WIDTH-1:1]}; bit_cnt++.
//    No strobe means no shift: gaps between bits are legal and of any length.
//  - Frame complete: strobe while bit_cnt==FRAME-1.
//    FRAME=WIDTH, or WIDTH+1 with parity. On completion bit_cnt <= 0.
//  - The completed word is {serial_in, sr[WIDTH-1:1]} (data bits only).
//  - Transfer on completion:
//    - If !out_valid, or out_valid & out_ready in the same cycle:
//      parallel_out <= word; out_valid <= 1.
//    - Else word discarded; overrun=1 for exactly that cycle; parallel_out/out_valid unchanged.
//  - Latency: word and out_valid appear on the cycle after the final bit's strobe.
//  - Consume: out_valid & out_ready with no transfer that cycle -> out_valid <= 0.
//    parallel_out keeps its last value after consumption.
//  - Back-to-back: completion + consume in the same cycle reloads; out_valid stays 1, no bubble.
//  - clear: sr, bit_cnt <= 0. clear has priority over serial_valid in the same cycle (bit lost).
//    clear does not affect parallel_out, out_valid or parity_err.
//  - reset mid-frame or mid-hold: all state returns to reset values; held word lost.
//  - busy is combinational: (bit_cnt != 0).
//  - overrun is registered, so it is high on the cycle after the dropping strobe.
// CONFIGURATION
//  Macro PARITY_CHECK_EN.
//  - Defined: frame = WIDTH data bits + 1 even-parity bit, received last.
//    - Parity bit is not stored in parallel_out.
//    - parity_err <= ^{data, parity} on transfer; it travels with the word and has the same
//      visibility as out_valid.
//    - On an overrun drop, parity_err is not updated.
//  - Undefined: frame = WIDTH bits, no parity logic; parity_err tied 0.
// TESTING (WIDTH=4)
//  1. reset=1 for 2 cycles with random serial inputs
//     -> parallel_out=0, out_valid=0, busy=0, bit_cnt=0, overrun=0.
//  2. Strobe bits 0,1,0,1 on consecutive cycles, out_ready=1
//     -> cycle after 4th strobe: parallel_out=4'b1010, out_valid=1 for exactly 1 cycle.
//  3. out_ready=0; send 1010 then 1110 (bits 0,1,1,1)
//     -> second completion: overrun pulse; parallel_out stays 1010.
//     -> raise out_ready: out_valid drops next cycle.
//  4. Send 2 bits, assert clear (with serial_valid=1), then send 1,1,0,0
//     -> bit_cnt=0 after clear; parallel_out=4'b0011, no overrun.
//  5. Bits 1,0,0,1 with 3-cycle gaps between strobes, then a second word completing
//     on the cycle it is consumed
//     -> 4'b1001, then second word; out_valid held with no bubble.
//  6. PARITY_CHECK_EN: send 1010 + parity 0 -> parity_err=0;
//     send 1010 + parity 1 -> parity_err=1 with word 4'b1010.

Source files
------------

// File: rtl/sipo_deser.sv
// ============================================================================
//  Module      : sipo_deser
//  Description : LSB-first serial-in parallel-out deserializer, double-buffered
//                with a valid/ready output. Optional macro PARITY_CHECK_EN adds
//                a trailing even-parity bit per frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_deser #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    output logic             parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int c_FRAME = WIDTH + 1;
`else
    localparam int c_FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(c_FRAME - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_pout;
    logic             r_valid;
    logic             r_overrun;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_accept;
    logic             w_drop;

    always_comb begin
        w_shifted  = {serial_in, r_sr[WIDTH-1:1]};
        w_complete = serial_valid && !clear && (r_cnt == c_LAST);
        w_accept   = w_complete && (!r_valid || out_ready);
        w_drop     = w_complete && r_valid && !out_ready;
`ifdef PARITY_CHECK_EN
        // The final strobe carries the parity bit, so the data is already in r_sr.
        w_word     = r_sr;
`else
        w_word     = w_shifted;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (serial_valid) begin
            r_sr  <= w_shifted;
            r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_accept) begin
                r_pout  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perr <= 1'b0;
        end else if (w_accept) begin
            r_perr <= ^{r_sr, serial_in};
        end
    end

    // Flag is only meaningful while its word is being offered.
    assign parity_err = r_perr && r_valid;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = r_pout;
    assign out_valid    = r_valid;
    assign overrun      = r_overrun;
    assign bit_cnt      = r_cnt;
    assign busy         = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
// ============================================================================
//  Module      : tb_sipo_deser
//  Description : Scoreboard bench for sipo_deser (WIDTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sipo_deser;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             serial_in = 1'b0;
    logic             serial_valid = 1'b0;
    logic             clear = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             parity_err;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clear        (clear),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .bit_cnt      (bit_cnt),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    // Consumer side: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mon_word: got %b, want no word (queue empty)", parallel_out);
            end else begin
                logic [WIDTH-1:0] exp_w;
                exp_w = exp_q.pop_front();
                if (parallel_out !== exp_w) begin
                    bad++;
                    $display("FAIL mon_word: got %b want %b", parallel_out, exp_w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        step();
        serial_valid = 1'b0;
    endtask

    // Sends one frame (parity appended when enabled); keep=1 means the word must reach the consumer.
    task automatic send_word(input logic [WIDTH-1:0] d, input int gap,
                             input bit ready_last, input bit keep);
        if (keep) exp_q.push_back(d);
        for (int i = 0; i < FRAME; i++) begin
            logic b;
            if (i < WIDTH) b = d[i];
            else           b = ^d;
            if (ready_last && i == FRAME - 1) out_ready = 1'b1;
            send_bit(b);
            if (i != FRAME - 1) repeat (gap) step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            serial_in    = 1'($urandom);
            serial_valid = 1'($urandom);
            clear        = 1'($urandom);
            step();
        end
        serial_valid = 1'b0;
        clear        = 1'b0;
        total++; if (parallel_out !== 4'b0000) begin bad++; $display("FAIL rst_pout: got %b want 0000", parallel_out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", bit_cnt); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b want 0", parity_err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_word(4'b1010, 0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        total++; if (parallel_out !== 4'b1010) begin bad++; $display("FAIL basic_pout: got %b want 1010", parallel_out); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL basic_cnt: got %0d want 0", bit_cnt); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        total++; if (parallel_out !== 4'b1010) begin bad++; $display("FAIL basic_pout_keep: got %b want 1010", parallel_out); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(4'b1010, 0, 1'b0, 1'b1);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first: got %b want 0", overrun); end
        send_word(4'b1110, 0, 1'b0, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        total++; if (parallel_out !== 4'b1010) begin bad++; $display("FAIL ovr_pout: got %b want 1010", parallel_out); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
        step();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        total++; if (bit_cnt !== CNT_W'(2)) begin bad++; $display("FAIL clr_cnt_pre: got %0d want 2", bit_cnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy_pre: got %b want 1", busy); end
        clear        = 1'b1;
        serial_in    = 1'b1;
        serial_valid = 1'b1;
        step();
        clear        = 1'b0;
        serial_valid = 1'b0;
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", bit_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy: got %b want 0", busy); end
        send_word(4'b0011, 0, 1'b0, 1'b1);
        total++; if (parallel_out !== 4'b0011) begin bad++; $display("FAIL clr_pout: got %b want 0011", parallel_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun: got %b want 0", overrun); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_word(4'b1001, 3, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
        total++; if (parallel_out !== 4'b1001) begin bad++; $display("FAIL b2b_pout1: got %b want 1001", parallel_out); end
        send_word(4'b0110, 1, 1'b1, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_nobubble: got %b want 1", out_valid); end
        total++; if (parallel_out !== 4'b0110) begin bad++; $display("FAIL b2b_pout2: got %b want 0110", parallel_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(4'b0101, 0, 1'b0, 1'b0);
        send_bit(1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        total++; if (parallel_out !== 4'b0000) begin bad++; $display("FAIL rmid_pout: got %b want 0000", parallel_out); end
        total++; if (bit_cnt !== '0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_parity();
        out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
        exp_q.push_back(4'b1010);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_ok: got %b want 0", parity_err); end
        step();
        exp_q.push_back(4'b1010);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1);
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err: got %b want 1", parity_err); end
        total++; if (parallel_out !== 4'b1010) begin bad++; $display("FAIL par_pout: got %b want 1010", parallel_out); end
        step();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_consumed: got %b want 0", parity_err); end
`else
        send_word(4'b1011, 0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL par_valid: got %b want 1", out_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_tied: got %b want 0", parity_err); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        repeat (2) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_empty: got %0d words pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
